// File: rtl/accumulator_tree.sv
// Pipelined signed adder tree: sums TAPS products of one FIR sample.
// One register stage per tree level, then a registered output stage that
// rounds (half toward +inf), arithmetically shifts and saturates.
// out_ovf is a sticky flag for saturation events on valid outputs.
module accumulator_tree #(
  parameter int TAPS     = 8,
  parameter int MULTBITS = 32,
  parameter int SHIFT    = 0,
  parameter int OUTBITS  = MULTBITS + $clog2(TAPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [MULTBITS-1:0] multiplier_out [0:TAPS-1],
  input  logic                ovf_clr,
  output logic [OUTBITS-1:0]  out,
  output logic                out_valid,
  output logic                out_ovf
);

  localparam int LEVELS   = $clog2(TAPS);
  localparam int FULLBITS = MULTBITS + LEVELS;
  // Working width wide enough for the rounded sum and for the output range.
  localparam int EW       = (OUTBITS > FULLBITS + 1) ? OUTBITS : FULLBITS + 1;
  localparam int RSH      = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [FULLBITS:0] RND = (SHIFT > 0) ? ((FULLBITS+1)'(1) << RSH) : '0;
  localparam logic signed [EW-1:0] MAXV = {{(EW-OUTBITS+1){1'b0}}, {(OUTBITS-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = ~MAXV;

  // Level k holds ceil(TAPS/2^k) partial sums; level 0 is the sign-extended
  // input itself. An odd element at the end of a level passes through
  // unchanged, which is the same as pairing it with a zero leaf.
  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    localparam int N     = (TAPS + (1 << k) - 1) >> k;
    localparam int KP    = (k > 0) ? k - 1 : 0;
    localparam int NPREV = (TAPS + (1 << KP) - 1) >> KP;

    logic signed [FULLBITS-1:0] sum [0:N-1];
    logic                       vld;

    if (k == 0) begin : g_leaf
      for (genvar j = 0; j < N; j++) begin : g_ext
        assign sum[j] = FULLBITS'($signed(multiplier_out[j]));
      end
      assign vld = in_valid;
    end else begin : g_add
      logic signed [FULLBITS-1:0] nxt [0:N-1];

      for (genvar j = 0; j < N; j++) begin : g_node
        if (2*j + 1 < NPREV) begin : g_pair
          assign nxt[j] = g_lvl[k-1].sum[2*j] + g_lvl[k-1].sum[2*j+1];
        end else begin : g_pass
          assign nxt[j] = g_lvl[k-1].sum[2*j];
        end
      end

      // Level register: data loads only with a valid sample, valid always shifts.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld <= 1'b0;
          for (int j = 0; j < N; j++) sum[j] <= '0;
        end else begin
          vld <= g_lvl[k-1].vld;
          if (g_lvl[k-1].vld) sum <= nxt;
        end
      end
    end
  end

  logic signed [FULLBITS-1:0] tree_sum;
  logic                       tree_vld;
  logic signed [FULLBITS:0]   rnd;
  logic signed [EW-1:0]       shifted;
  logic                       sat_hi;
  logic                       sat_lo;

  assign tree_sum = g_lvl[LEVELS].sum[0];
  assign tree_vld = g_lvl[LEVELS].vld;

  // Round half toward +inf, shift, and detect out-of-range results.
  always_comb begin
    rnd     = {tree_sum[FULLBITS-1], tree_sum} + RND;
    shifted = EW'(rnd >>> SHIFT);
    sat_hi  = shifted > MAXV;
    sat_lo  = shifted < MINV;
  end

  // Output register with hold-on-bubble and sticky overflow (set beats clear).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= tree_vld;
      if (tree_vld) begin
        if (sat_hi)      out <= MAXV[OUTBITS-1:0];
        else if (sat_lo) out <= MINV[OUTBITS-1:0];
        else             out <= shifted[OUTBITS-1:0];
      end
      if (tree_vld && (sat_hi || sat_lo)) out_ovf <= 1'b1;
      else if (ovf_clr)                   out_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_accumulator_tree.sv
// Directed bench for accumulator_tree: four instances cover the default
// configuration, rounding (SHIFT=2), saturation (OUTBITS=16) and TAPS=5.
module tb_accumulator_tree;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, ovf_clr;
  logic [31:0] mult [0:7];
  logic        rst_odd, in_valid_odd;
  logic [31:0] mult_odd [0:4];

  logic signed [34:0] out_def, out_rnd, out_odd;
  logic signed [15:0] out_sat;
  logic vld_def, vld_rnd, vld_sat, vld_odd;
  logic ovf_def, ovf_rnd, ovf_sat, ovf_odd;

  int n_checks = 0;
  int n_errs   = 0;
  int pv [2][10];

  accumulator_tree #(.TAPS(8), .MULTBITS(32)) u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .multiplier_out(mult),
    .ovf_clr(ovf_clr), .out(out_def), .out_valid(vld_def), .out_ovf(ovf_def));

  accumulator_tree #(.TAPS(8), .MULTBITS(32), .SHIFT(2)) u_rnd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .multiplier_out(mult),
    .ovf_clr(ovf_clr), .out(out_rnd), .out_valid(vld_rnd), .out_ovf(ovf_rnd));

  accumulator_tree #(.TAPS(8), .MULTBITS(32), .SHIFT(0), .OUTBITS(16)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .multiplier_out(mult),
    .ovf_clr(ovf_clr), .out(out_sat), .out_valid(vld_sat), .out_ovf(ovf_sat));

  accumulator_tree #(.TAPS(5), .MULTBITS(32)) u_odd (
    .clk(clk), .rst_n(rst_odd), .in_valid(in_valid_odd), .multiplier_out(mult_odd),
    .ovf_clr(ovf_clr), .out(out_odd), .out_valid(vld_odd), .out_ovf(ovf_odd));

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_all(input logic [31:0] v);
    for (int i = 0; i < 8; i++) mult[i] = v;
  endtask

  task automatic load_one(input logic [31:0] v);
    for (int i = 0; i < 8; i++) mult[i] = '0;
    mult[0] = v;
  endtask

  // One-cycle valid pulse, return just after the 4th rising edge.
  task automatic fire();
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(3);
  endtask

  task automatic fire_odd();
    in_valid_odd = 1'b1;
    tick(1);
    in_valid_odd = 1'b0;
    tick(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rst_odd = 1'b0;
    in_valid = 1'b0; in_valid_odd = 1'b0; ovf_clr = 1'b0;
    load_all('0);
    for (int i = 0; i < 5; i++) mult_odd[i] = '0;
    pv = '{'{1, 2, 3, 4, 5, 6, 0, 0, 0, 0},
           '{1, 2, 0, 3, 4, 5, 0, 6, 0, 0}};
    tick(3);
    rst_n = 1'b1; rst_odd = 1'b1;
    tick(1);

    check_val("rst_out",     out_def, 0);
    check_val("rst_vld",     vld_def, 0);
    check_val("rst_ovf",     ovf_def, 0);
    check_val("rst_sat_out", out_sat, 0);
    check_val("rst_sat_ovf", ovf_sat, 0);
    check_val("rst_odd_vld", vld_odd, 0);
    check_val("rst_odd_out", out_odd, 0);

    // Basic sum 0..7 with exact latency
    for (int i = 0; i < 8; i++) mult[i] = i;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    check_val("lat_e1", vld_def, 0);
    tick(2);
    check_val("lat_e3", vld_def, 0);
    tick(1);
    check_val("lat_e4", vld_def, 1);
    check_val("sum28",  out_def, 28);
    tick(1);
    check_val("vld_drop", vld_def, 0);
    check_val("hold28",   out_def, 28);

    // Signed extremes
    load_all(32'hFFFF_FFFF);
    fire();
    check_val("all_m1", out_def, -8);
    load_all(32'h7FFF_FFFF);
    fire();
    check_val("all_max",     out_def, 64'sd17179869176);
    check_val("all_max_ovf", ovf_def, 0);

    // Streaming, then the same with bubbles
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 14; c++) begin
        if (c >= 4) begin
          check_val($sformatf("stream%0d_vld_c%0d", r, c), vld_def, (pv[r][c-4] != 0));
          if (pv[r][c-4] != 0)
            check_val($sformatf("stream%0d_out_c%0d", r, c), out_def, pv[r][c-4]);
        end
        if (c < 10) begin
          in_valid = (pv[r][c] != 0);
          load_one(pv[r][c]);
        end else begin
          in_valid = 1'b0;
        end
        tick(1);
      end
    end

    // Rounding, SHIFT=2
    load_one(32'd6);
    fire();
    check_val("rnd_p6", out_rnd, 2);
    load_one(-32'sd6);
    fire();
    check_val("rnd_m6", out_rnd, -1);
    load_one(32'd5);
    fire();
    check_val("rnd_p5", out_rnd, 1);

    // Saturation, OUTBITS=16
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check_val("sat_clr0", ovf_sat, 0);
    load_all(32'd10000);
    fire();
    check_val("sat_hi",     out_sat, 32767);
    check_val("sat_hi_ovf", ovf_sat, 1);
    load_all(-32'sd10000);
    fire();
    check_val("sat_lo", out_sat, -32768);
    load_all(32'd1);
    fire();
    check_val("sat_sum8",   out_sat, 8);
    check_val("sat_sticky", ovf_sat, 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check_val("sat_clr", ovf_sat, 0);
    load_all(32'd10000);
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(2);
    check_val("sat_pre", ovf_sat, 0);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check_val("sat_set_vld",   vld_sat, 1);
    check_val("sat_set_wins",  ovf_sat, 1);

    // TAPS=5: odd size, then reset mid-flight
    for (int i = 0; i < 5; i++) mult_odd[i] = i + 1;
    in_valid_odd = 1'b1;
    tick(1);
    in_valid_odd = 1'b0;
    tick(2);
    check_val("odd_e3", vld_odd, 0);
    tick(1);
    check_val("odd_vld", vld_odd, 1);
    check_val("odd_15",  out_odd, 15);

    for (int i = 0; i < 5; i++) mult_odd[i] = 2;
    in_valid_odd = 1'b1;
    tick(1);
    in_valid_odd = 1'b0;
    tick(1);
    rst_odd = 1'b0;
    tick(1);
    rst_odd = 1'b1;
    check_val("odd_rst_out", out_odd, 0);
    for (int c = 0; c < 4; c++) begin
      check_val($sformatf("odd_rst_vld%0d", c), vld_odd, 0);
      tick(1);
    end
    check_val("odd_rst_hold", out_odd, 0);

    for (int i = 0; i < 5; i++) mult_odd[i] = i + 1;
    fire_odd();
    check_val("odd_after_rst", out_odd, 15);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
